// File: rtl/vga_write_arbiter_pkg.sv
// ============================================================================
// Module  : vga_write_arbiter_pkg
// Brief   : Shared constants and state encoding for the VGA write arbiter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package vga_write_arbiter_pkg;

    localparam int REQ_TOWER  = 0;
    localparam int REQ_CAR    = 1;
    localparam int REQ_MIDDLE = 2;
    localparam int REQ_LASER  = 3;

    localparam int COLOUR_W = 9;
    localparam int COORD_W  = 15;
    localparam int ADDR_W   = 15;
    localparam int HOLD_W   = 15;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN  = 2'd1,
        ST_GAP  = 2'd2
    } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/vga_write_arbiter_rr_picker.sv
// ============================================================================
// Module  : rr_picker
// Brief   : Combinational round-robin one-hot selector; search starts one
//           past the previous owner.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_picker #(
    parameter int NREQ  = 4,
    parameter int IDX_W = 2
) (
    input  logic [NREQ-1:0]  i_req,
    input  logic [IDX_W-1:0] i_last_owner,
    output logic             o_valid,
    output logic [IDX_W-1:0] o_idx,
    output logic [NREQ-1:0]  o_onehot
);

    logic [IDX_W-1:0] w_cand;

    always_comb begin
        o_valid  = 1'b0;
        o_idx    = '0;
        o_onehot = '0;
        w_cand   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            w_cand = IDX_W'((int'(i_last_owner) + k) % NREQ);
            if (!o_valid && i_req[w_cand]) begin
                o_valid          = 1'b1;
                o_idx            = w_cand;
                o_onehot[w_cand] = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/vga_write_arbiter.sv
// ============================================================================
// Module  : vga_write_arbiter
// Brief   : Round-robin ownership arbiter muxing requester pixels onto VGA.
//           Optional grant timeout enabled by VGA_WRITE_ARBITER_TIMEOUT_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_write_arbiter
    import vga_write_arbiter_pkg::*;
#(
    parameter int NREQ           = 4,
    parameter int TIMEOUT_CYCLES = 20000
) (
    input  logic                     Clock,
    input  logic                     resetn,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ-1:0]          wr,
    input  logic [NREQ*COLOUR_W-1:0] colour_in,
    input  logic [NREQ*COORD_W-1:0]  coord_in,
    input  logic [NREQ*ADDR_W-1:0]   mem_add_in,
    output logic [NREQ-1:0]          gnt,
    output logic [COLOUR_W-1:0]      colour,
    output logic [COORD_W-1:0]       coordinates,
    output logic                     VGA_write_enable,
    output logic [ADDR_W-1:0]        mem_add,
    output logic                     busy,
    output logic                     timeout_err
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    arb_state_t          r_state;
    arb_state_t          w_state_nxt;
    logic [IDX_W-1:0]    r_owner;
    logic [IDX_W-1:0]    r_last_owner;
    logic [NREQ-1:0]     r_gnt;
    logic [COLOUR_W-1:0] r_colour;
    logic [COORD_W-1:0]  r_coord;
    logic [ADDR_W-1:0]   r_mem_add;
    logic                r_we;
    logic                r_timeout_err;

    logic                w_pick_valid;
    logic [IDX_W-1:0]    w_pick_idx;
    logic [NREQ-1:0]     w_pick_onehot;
    logic                w_owner_req;
    logic                w_timeout;

    rr_picker #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_rr_picker (
        .i_req        (req),
        .i_last_owner (r_last_owner),
        .o_valid      (w_pick_valid),
        .o_idx        (w_pick_idx),
        .o_onehot     (w_pick_onehot)
    );

    assign w_owner_req = req[r_owner];

`ifdef VGA_WRITE_ARBITER_TIMEOUT_EN
    localparam logic [HOLD_W-1:0] c_HOLD_LAST = HOLD_W'(TIMEOUT_CYCLES - 1);

    logic [HOLD_W-1:0] r_hold;

    always_ff @(posedge Clock) begin
        if (!resetn) begin
            r_hold <= '0;
        end else if (r_state == ST_IDLE && w_state_nxt == ST_OWN) begin
            r_hold <= '0;
        end else if (r_state == ST_OWN && r_hold != '1) begin
            r_hold <= r_hold + 1'b1;
        end
    end

    // A voluntary release on the limit cycle is not a revocation.
    assign w_timeout = (r_state == ST_OWN) && (r_hold == c_HOLD_LAST) && w_owner_req;
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge Clock) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_pick_valid) w_state_nxt = ST_OWN;
            ST_OWN:  if (!w_owner_req || w_timeout) w_state_nxt = ST_GAP;
            ST_GAP:  w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // A revoked owner becomes last_owner, so the rotation already ranks it
    // behind every other active requester at the next selection.
    always_ff @(posedge Clock) begin
        if (!resetn) begin
            r_owner       <= '0;
            r_last_owner  <= IDX_W'(NREQ - 1);
            r_gnt         <= '0;
            r_colour      <= '0;
            r_coord       <= '0;
            r_mem_add     <= '0;
            r_we          <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_timeout_err <= 1'b0;
            if (r_state == ST_IDLE && w_pick_valid) begin
                r_owner <= w_pick_idx;
                r_gnt   <= w_pick_onehot;
            end
            if (r_state == ST_OWN && w_state_nxt == ST_GAP) begin
                r_last_owner  <= r_owner;
                r_gnt         <= '0;
                r_timeout_err <= w_timeout;
            end
            if (r_state == ST_OWN) begin
                r_we      <= wr[r_owner] & w_owner_req;
                r_colour  <= colour_in[int'(r_owner)*COLOUR_W +: COLOUR_W];
                r_coord   <= coord_in[int'(r_owner)*COORD_W +: COORD_W];
                r_mem_add <= mem_add_in[int'(r_owner)*ADDR_W +: ADDR_W];
            end else begin
                r_we      <= 1'b0;
                r_colour  <= '0;
                r_coord   <= '0;
                r_mem_add <= '0;
            end
        end
    end

    assign gnt              = r_gnt;
    assign colour           = r_colour;
    assign coordinates      = r_coord;
    assign mem_add          = r_mem_add;
    assign VGA_write_enable = r_we;
    assign timeout_err      = r_timeout_err;
    assign busy             = (r_state != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_vga_write_arbiter.sv
// ============================================================================
// Module  : tb_vga_write_arbiter
// Brief   : Self-checking bench with directed scenarios and random traffic
//           against an ownership-level reference model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vga_write_arbiter;
    import vga_write_arbiter_pkg::*;

    localparam int N  = 4;
    localparam int TO = 8;
`ifdef VGA_WRITE_ARBITER_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic                  Clock  = 1'b0;
    logic                  resetn = 1'b0;
    logic [N-1:0]          req    = '0;
    logic [N-1:0]          wr     = '0;
    logic [N*COLOUR_W-1:0] colour_in;
    logic [N*COORD_W-1:0]  coord_in;
    logic [N*ADDR_W-1:0]   mem_add_in;
    logic [N-1:0]          gnt;
    logic [COLOUR_W-1:0]   colour;
    logic [COORD_W-1:0]    coordinates;
    logic                  VGA_write_enable;
    logic [ADDR_W-1:0]     mem_add;
    logic                  busy;
    logic                  timeout_err;

    logic [COLOUR_W-1:0] col_a [N];
    logic [COORD_W-1:0]  crd_a [N];
    logic [ADDR_W-1:0]   adr_a [N];

    int n_checks = 0;
    int n_err    = 0;

    // Reference model: who owns the screen, whether a gap is pending,
    // and what the VGA side should show after the next edge.
    int                  m_own  = -1;
    bit                  m_gap  = 1'b0;
    int                  m_last = N - 1;
    int                  m_hold = 0;
    logic [N-1:0]        e_gnt  = '0;
    logic                e_we   = 1'b0;
    logic                e_to   = 1'b0;
    logic [COLOUR_W-1:0] e_col  = '0;
    logic [COORD_W-1:0]  e_crd  = '0;
    logic [ADDR_W-1:0]   e_adr  = '0;

    vga_write_arbiter #(
        .NREQ           (N),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .Clock            (Clock),
        .resetn           (resetn),
        .req              (req),
        .wr               (wr),
        .colour_in        (colour_in),
        .coord_in         (coord_in),
        .mem_add_in       (mem_add_in),
        .gnt              (gnt),
        .colour           (colour),
        .coordinates      (coordinates),
        .VGA_write_enable (VGA_write_enable),
        .mem_add          (mem_add),
        .busy             (busy),
        .timeout_err      (timeout_err)
    );

    always #5 Clock = ~Clock;

    always_comb begin
        colour_in  = '0;
        coord_in   = '0;
        mem_add_in = '0;
        for (int i = 0; i < N; i++) begin
            colour_in[i*COLOUR_W +: COLOUR_W] = col_a[i];
            coord_in[i*COORD_W +: COORD_W]    = crd_a[i];
            mem_add_in[i*ADDR_W +: ADDR_W]    = adr_a[i];
        end
    end

    task automatic check(input string tag, input logic [35:0] obs, input logic [35:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic rand_data();
        for (int i = 0; i < N; i++) begin
            col_a[i] = COLOUR_W'($urandom);
            crd_a[i] = COORD_W'($urandom);
            adr_a[i] = ADDR_W'($urandom);
        end
    endtask

    task automatic model_step();
        bit timed;
        int cand;
        e_to = 1'b0;
        if (!resetn) begin
            m_own = -1; m_gap = 1'b0; m_last = N - 1; m_hold = 0;
            e_gnt = '0; e_we = 1'b0; e_col = '0; e_crd = '0; e_adr = '0;
        end else if (m_own >= 0) begin
            e_we  = wr[m_own] & req[m_own];
            e_col = col_a[m_own];
            e_crd = crd_a[m_own];
            e_adr = adr_a[m_own];
            timed = TO_EN && (m_hold == TO - 1) && req[m_own];
            if (!req[m_own] || timed) begin
                m_last = m_own;
                m_own  = -1;
                m_gap  = 1'b1;
                e_gnt  = '0;
                e_to   = timed;
            end else if (m_hold < 32767) begin
                m_hold++;
            end
        end else begin
            e_we = 1'b0; e_col = '0; e_crd = '0; e_adr = '0;
            if (m_gap) begin
                m_gap = 1'b0;
            end else begin
                for (int k = 1; k <= N; k++) begin
                    cand = (m_last + k) % N;
                    if (req[cand]) begin
                        m_own  = cand;
                        m_hold = 0;
                        e_gnt  = N'(1 << cand);
                        break;
                    end
                end
            end
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge Clock);
        #1;
        check("gnt", 36'(gnt), 36'(e_gnt));
        check("we", 36'(VGA_write_enable), 36'(e_we));
        check("colour", 36'(colour), 36'(e_col));
        check("coordinates", 36'(coordinates), 36'(e_crd));
        check("mem_add", 36'(mem_add), 36'(e_adr));
        check("timeout_err", 36'(timeout_err), 36'(e_to));
        check("busy", 36'(busy), 36'((m_own >= 0) || m_gap));
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        req    = '0;
        wr     = '0;
        cycle();
        resetn = 1'b1;
    endtask

    initial begin
        int                  nwr;
        int                  tower_cycles;
        int                  pulses;
        int                  first_pulse;
        bit                  car_seen;
        logic [COLOUR_W-1:0] prev_mid;

        rand_data();
        do_reset();
        check("reset_gnt", 36'(gnt), 36'(0));
        check("reset_busy", 36'(busy), 36'(0));

        // Tower burst of 10 request cycles yields 9 writes
        req = 4'b0001; wr = 4'b1111; nwr = 0;
        for (int c = 0; c < 10; c++) begin
            rand_data();
            cycle();
            if (c == 0) check("s1_first_gnt", 36'(gnt), 36'(4'b0001));
            if (VGA_write_enable) nwr++;
        end
        req = '0;
        for (int c = 0; c < 3; c++) begin
            cycle();
            if (VGA_write_enable) nwr++;
        end
        check("s1_write_count", 36'(nwr), 36'(9));

        // Car beats laser on the first contest, laser follows after a gap
        do_reset();
        req = 4'b1010; wr = 4'b1010;
        rand_data();
        cycle();
        check("s2_car_first", 36'(gnt), 36'(4'b0010));
        for (int c = 0; c < 4; c++) begin rand_data(); cycle(); end
        req = 4'b1000;
        cycle();
        check("s2_gap_gnt", 36'(gnt), 36'(0));
        cycle();
        check("s2_idle_gnt", 36'(gnt), 36'(0));
        cycle();
        check("s2_laser_gnt", 36'(gnt), 36'(4'b1000));
        req = '0;
        for (int c = 0; c < 3; c++) cycle();

        // Middle owns; laser waits, car strobes are ignored
        do_reset();
        req = 4'b0100; wr = 4'b0100;
        rand_data();
        cycle();
        check("s3_mid_gnt", 36'(gnt), 36'(4'b0100));
        cycle();
        req = 4'b1100; wr = 4'b0110;
        for (int c = 0; c < 4; c++) begin
            rand_data();
            prev_mid = col_a[REQ_MIDDLE];
            cycle();
            check("s3_mid_we", 36'(VGA_write_enable), 36'(1));
            check("s3_mid_colour", 36'(colour), 36'(prev_mid));
        end
        req = 4'b1000; wr = '0;
        cycle();
        cycle();
        check("s3_no_gnt_yet", 36'(gnt), 36'(0));
        cycle();
        check("s3_laser_gnt", 36'(gnt), 36'(4'b1000));
        req = '0;
        for (int c = 0; c < 3; c++) cycle();

        // Reset in the middle of an active burst
        do_reset();
        req = 4'b0001; wr = 4'b0001;
        for (int c = 0; c < 3; c++) begin rand_data(); cycle(); end
        check("s4_we_active", 36'(VGA_write_enable), 36'(1));
        resetn = 1'b0;
        cycle();
        check("s4_gnt", 36'(gnt), 36'(0));
        check("s4_we", 36'(VGA_write_enable), 36'(0));
        check("s4_colour", 36'(colour), 36'(0));
        check("s4_busy", 36'(busy), 36'(0));
        check("s4_timeout", 36'(timeout_err), 36'(0));
        resetn = 1'b1;
        req = '0;
        for (int c = 0; c < 2; c++) cycle();

        // Tower hogs the screen while car waits
        do_reset();
        req = 4'b0011; wr = 4'b0011;
        tower_cycles = 0; pulses = 0; first_pulse = -1; car_seen = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            rand_data();
            cycle();
            if (gnt == 4'b0001) tower_cycles++;
            if (gnt == 4'b0010) car_seen = 1'b1;
            if (timeout_err) begin
                pulses++;
                if (first_pulse < 0) first_pulse = c;
            end
        end
        check("s5_tower_cycles", 36'(tower_cycles), 36'(TO_EN ? 8 : 20));
        check("s5_first_pulse", 36'(first_pulse), 36'(TO_EN ? 9 : -1));
        check("s5_car_granted", 36'(car_seen), 36'(TO_EN));
        check("s5_any_pulse", 36'(pulses > 0), 36'(TO_EN));
        req = '0;
        for (int c = 0; c < 4; c++) cycle();

        // Random traffic with sticky requests and rare resets
        do_reset();
        for (int c = 0; c < 500; c++) begin
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, 7) == 0) req[i] = ~req[i];
            wr     = N'($urandom);
            resetn = ($urandom_range(0, 63) != 0);
            rand_data();
            cycle();
        end
        resetn = 1'b1;

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
